ysyx_23060208_mem_arbiter: RTL and testbench

YSYX_23060208_MEM_ARBITER -- requirements
Module: ysyx_23060208_mem_arbiter

---
 rtl/ysyx_23060208_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_23060208_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060208_mem_arbiter
// Brief    : Shares one AXI-lite style memory slave between the IFU (read) and
//            the EXU (read/write); one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060208_mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU read master
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // EXU read master
  input  logic [DATA_WIDTH-1:0] exu_araddr,
  input  logic                  exu_arvalid,
  output logic                  exu_arready,
  output logic [DATA_WIDTH-1:0] exu_rdata,
  output logic [1:0]            exu_rresp,
  output logic                  exu_rvalid,
  input  logic                  exu_rready,
  // EXU write master
  input  logic [DATA_WIDTH-1:0] exu_awaddr,
  input  logic                  exu_awvalid,
  output logic                  exu_awready,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic [2:0]            exu_wstrb,
  input  logic                  exu_wvalid,
  output logic                  exu_wready,
  output logic [1:0]            exu_bresp,
  output logic                  exu_bvalid,
  input  logic                  exu_bready,
  // Memory slave
  output logic [DATA_WIDTH-1:0] mem_awaddr,
  output logic                  mem_awvalid,
  input  logic                  mem_awready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_wstrb,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  input  logic [1:0]            mem_bresp,
  input  logic                  mem_bvalid,
  output logic                  mem_bready,
  output logic [DATA_WIDTH-1:0] mem_araddr,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  // One-hot {exu_write, exu_read, ifu_read}
  output logic [2:0]            grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IFU_R = 2'd1,
    ST_EXU_R = 2'd2,
    ST_EXU_W = 2'd3
  } state_e;

  localparam logic [2:0] c_GNT_NONE = 3'b000;
  localparam logic [2:0] c_GNT_IFU  = 3'b001;
  localparam logic [2:0] c_GNT_EXUR = 3'b010;
  localparam logic [2:0] c_GNT_EXUW = 3'b100;

  state_e     state_q;
  logic [2:0] grant_q;
  logic       last_rd_exu_q;
  // Address/data handshake flags stop a still-held valid from issuing twice.
  logic       ar_done_q;
  logic       aw_done_q;
  logic       w_done_q;

  logic       w_exu_rd_wins;

  assign grant         = grant_q;
  assign w_exu_rd_wins = exu_arvalid && (!ifu_arvalid || !last_rd_exu_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= c_GNT_NONE;
      last_rd_exu_q <= 1'b1;
      ar_done_q     <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ar_done_q <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (exu_awvalid) begin
            state_q <= ST_EXU_W;
            grant_q <= c_GNT_EXUW;
          end else if (w_exu_rd_wins) begin
            state_q       <= ST_EXU_R;
            grant_q       <= c_GNT_EXUR;
            last_rd_exu_q <= 1'b1;
          end else if (ifu_arvalid) begin
            state_q       <= ST_IFU_R;
            grant_q       <= c_GNT_IFU;
            last_rd_exu_q <= 1'b0;
          end
        end
        ST_IFU_R, ST_EXU_R: begin
          if (mem_arvalid && mem_arready) ar_done_q <= 1'b1;
          if (mem_rvalid && mem_rready) begin
            state_q <= ST_IDLE;
            grant_q <= c_GNT_NONE;
          end
        end
        ST_EXU_W: begin
          if (mem_awvalid && mem_awready) aw_done_q <= 1'b1;
          if (mem_wvalid && mem_wready)   w_done_q  <= 1'b1;
          if (mem_bvalid && mem_bready) begin
            state_q <= ST_IDLE;
            grant_q <= c_GNT_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= c_GNT_NONE;
        end
      endcase
    end
  end

  // Channel muxes: everything not owned by the current grant stays at zero.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    exu_arready = 1'b0;
    exu_rdata   = '0;
    exu_rresp   = 2'b00;
    exu_rvalid  = 1'b0;
    exu_awready = 1'b0;
    exu_wready  = 1'b0;
    exu_bresp   = 2'b00;
    exu_bvalid  = 1'b0;
    mem_awaddr  = '0;
    mem_awvalid = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = 3'b000;
    mem_wvalid  = 1'b0;
    mem_bready  = 1'b0;
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    case (state_q)
      ST_IFU_R: begin
        mem_araddr  = ifu_araddr;
        mem_arvalid = ifu_arvalid && !ar_done_q;
        ifu_arready = mem_arready && !ar_done_q;
        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        ifu_rvalid  = mem_rvalid;
        mem_rready  = ifu_rready;
      end
      ST_EXU_R: begin
        mem_araddr  = exu_araddr;
        mem_arvalid = exu_arvalid && !ar_done_q;
        exu_arready = mem_arready && !ar_done_q;
        exu_rdata   = mem_rdata;
        exu_rresp   = mem_rresp;
        exu_rvalid  = mem_rvalid;
        mem_rready  = exu_rready;
      end
      ST_EXU_W: begin
        mem_awaddr  = exu_awaddr;
        mem_awvalid = exu_awvalid && !aw_done_q;
        exu_awready = mem_awready && !aw_done_q;
        mem_wdata   = exu_wdata;
        mem_wstrb   = exu_wstrb;
        mem_wvalid  = exu_wvalid && !w_done_q;
        exu_wready  = mem_wready && !w_done_q;
        exu_bresp   = mem_bresp;
        exu_bvalid  = mem_bvalid;
        mem_bready  = exu_bready;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060208_mem_arbiter
// Brief    : Directed self-checking bench for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060208_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, exu_araddr, exu_awaddr, exu_wdata;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_rdata, exu_rdata;
  logic [1:0]  ifu_rresp, exu_rresp, exu_bresp;
  logic        exu_arvalid, exu_arready, exu_rvalid, exu_rready;
  logic        exu_awvalid, exu_awready, exu_wvalid, exu_wready;
  logic [2:0]  exu_wstrb;
  logic        exu_bvalid, exu_bready;
  logic [31:0] mem_awaddr, mem_wdata, mem_araddr, mem_rdata;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready;
  logic [2:0]  mem_wstrb;
  logic [1:0]  mem_bresp, mem_rresp;
  logic        mem_bvalid, mem_bready, mem_arvalid, mem_arready;
  logic        mem_rvalid, mem_rready;
  logic [2:0]  grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_23060208_mem_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .exu_araddr(exu_araddr), .exu_arvalid(exu_arvalid), .exu_arready(exu_arready),
    .exu_rdata(exu_rdata), .exu_rresp(exu_rresp), .exu_rvalid(exu_rvalid), .exu_rready(exu_rready),
    .exu_awaddr(exu_awaddr), .exu_awvalid(exu_awvalid), .exu_awready(exu_awready),
    .exu_wdata(exu_wdata), .exu_wstrb(exu_wstrb), .exu_wvalid(exu_wvalid), .exu_wready(exu_wready),
    .exu_bresp(exu_bresp), .exu_bvalid(exu_bvalid), .exu_bready(exu_bready),
    .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .grant(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    exu_araddr = '0; exu_arvalid = 0; exu_rready = 0;
    exu_awaddr = '0; exu_awvalid = 0; exu_wdata = '0; exu_wstrb = '0; exu_wvalid = 0; exu_bready = 0;
    mem_awready = 0; mem_wready = 0; mem_bresp = '0; mem_bvalid = 0;
    mem_arready = 0; mem_rdata = '0; mem_rresp = '0; mem_rvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Slave side of one read: AR accepted this cycle, R beat next cycle.
  task automatic serve_read(input bit is_exu, input logic [31:0] data);
    mem_arready = 1;
    tick();
    mem_arready = 0;
    if (is_exu) exu_arvalid = 0; else ifu_arvalid = 0;
    mem_rvalid = 1; mem_rdata = data; mem_rresp = 2'b00;
    tick();
    mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    ifu_arvalid = 1; exu_awvalid = 1; exu_wvalid = 1;
    mem_rvalid = 1; mem_bvalid = 1; mem_rdata = 32'hffffffff; mem_arready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b expected 000", grant); end
    checks++; if (mem_arvalid !== 1'b0 || mem_awvalid !== 1'b0 || mem_wvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mem_valids: got ar=%b aw=%b w=%b expected 0", mem_arvalid, mem_awvalid, mem_wvalid); end
    checks++; if (ifu_rvalid !== 1'b0 || exu_bvalid !== 1'b0 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL rst_master_outs: got rvalid=%b bvalid=%b arready=%b expected 0", ifu_rvalid, exu_bvalid, ifu_arready); end
    checks++; if (ifu_rdata !== 32'h0 || mem_rready !== 1'b0) begin
      errors++; $display("FAIL rst_data: got rdata=%h rready=%b expected 0", ifu_rdata, mem_rready); end
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_ifu_read();
    ifu_araddr = 32'h80000000; ifu_arvalid = 1; ifu_rready = 1; mem_arready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b000 || mem_arvalid !== 1'b0 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL ifu_idle_cycle: got grant=%b arvalid=%b arready=%b expected 000/0/0", grant, mem_arvalid, ifu_arready); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL ifu_grant_ar: got %b expected 001", grant); end
    checks++; if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h80000000 || ifu_arready !== 1'b1) begin
      errors++; $display("FAIL ifu_ar_route: got arvalid=%b araddr=%h arready=%b expected 1/80000000/1", mem_arvalid, mem_araddr, ifu_arready); end
    tick();
    ifu_arvalid = 0; mem_arready = 0;
    mem_rvalid = 1; mem_rdata = 32'h00000413;
    @(negedge clk);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL ifu_grant_r: got %b expected 001", grant); end
    checks++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h00000413 || mem_rready !== 1'b1) begin
      errors++; $display("FAIL ifu_r_route: got rvalid=%b rdata=%h rready=%b expected 1/00000413/1", ifu_rvalid, ifu_rdata, mem_rready); end
    checks++; if (exu_rvalid !== 1'b0 || exu_rdata !== 32'h0) begin
      errors++; $display("FAIL ifu_r_exu_quiet: got rvalid=%b rdata=%h expected 0/0", exu_rvalid, exu_rdata); end
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    @(negedge clk);
    checks++; if (grant !== 3'b000 || ifu_rvalid !== 1'b0) begin
      errors++; $display("FAIL ifu_back_idle: got grant=%b rvalid=%b expected 000/0", grant, ifu_rvalid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_read_collision();
    do_reset();
    ifu_araddr = 32'h80000004; exu_araddr = 32'h80001000;
    ifu_arvalid = 1; exu_arvalid = 1; ifu_rready = 1; exu_rready = 1;
    tick();
    mem_arready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b001 || mem_araddr !== 32'h80000004) begin
      errors++; $display("FAIL coll1_ifu_first: got grant=%b araddr=%h expected 001/80000004", grant, mem_araddr); end
    checks++; if (exu_arready !== 1'b0 || ifu_arready !== 1'b1) begin
      errors++; $display("FAIL coll1_readys: got exu=%b ifu=%b expected 0/1", exu_arready, ifu_arready); end
    serve_read(1'b0, 32'h11111111);
    // IFU re-requests at once, so this IDLE cycle is a second collision
    ifu_araddr = 32'h80000008; ifu_arvalid = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL coll_idle_gap: got %b expected 000", grant); end
    tick();
    mem_arready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b010 || mem_araddr !== 32'h80001000) begin
      errors++; $display("FAIL coll2_exu_first: got grant=%b araddr=%h expected 010/80001000", grant, mem_araddr); end
    checks++; if (exu_arready !== 1'b1 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL coll2_readys: got exu=%b ifu=%b expected 1/0", exu_arready, ifu_arready); end
    mem_arready = 1;
    tick();
    mem_arready = 0; exu_arvalid = 0;
    mem_rvalid = 1; mem_rdata = 32'hcafef00d;
    @(negedge clk);
    checks++; if (exu_rvalid !== 1'b1 || exu_rdata !== 32'hcafef00d || ifu_rvalid !== 1'b0) begin
      errors++; $display("FAIL coll2_exu_data: got rvalid=%b rdata=%h ifu_rvalid=%b expected 1/cafef00d/0", exu_rvalid, exu_rdata, ifu_rvalid); end
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    tick();
    mem_arready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b001 || mem_araddr !== 32'h80000008) begin
      errors++; $display("FAIL coll3_ifu_waited: got grant=%b araddr=%h expected 001/80000008", grant, mem_araddr); end
    serve_read(1'b0, 32'h22222222);
    clear_inputs();
  endtask

  task automatic test_exu_store();
    ifu_araddr = 32'h80000010; ifu_arvalid = 1; ifu_rready = 1; mem_arready = 1;
    exu_awaddr = 32'h80002000; exu_awvalid = 1;
    exu_wdata = 32'hdeadbeef; exu_wstrb = 3'b100; exu_wvalid = 1; exu_bready = 1;
    mem_wready = 1;
    @(negedge clk);
    checks++; if (exu_wready !== 1'b0 || mem_wvalid !== 1'b0) begin
      errors++; $display("FAIL st_idle_cycle: got wready=%b wvalid=%b expected 0/0", exu_wready, mem_wvalid); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL st_grant: got %b expected 100", grant); end
    checks++; if (mem_wvalid !== 1'b1 || mem_wdata !== 32'hdeadbeef || mem_wstrb !== 3'b100 || exu_wready !== 1'b1) begin
      errors++; $display("FAIL st_w_route: got wvalid=%b wdata=%h wstrb=%b wready=%b expected 1/deadbeef/100/1", mem_wvalid, mem_wdata, mem_wstrb, exu_wready); end
    checks++; if (exu_awready !== 1'b0 || ifu_arready !== 1'b0 || mem_arvalid !== 1'b0) begin
      errors++; $display("FAIL st_others_quiet: got awready=%b ifu_arready=%b mem_arvalid=%b expected 0/0/0", exu_awready, ifu_arready, mem_arvalid); end
    tick();
    exu_wvalid = 0; mem_wready = 0;
    @(negedge clk);
    checks++; if (mem_awvalid !== 1'b1 || mem_awaddr !== 32'h80002000 || mem_wvalid !== 1'b0) begin
      errors++; $display("FAIL st_aw_pending: got awvalid=%b awaddr=%h wvalid=%b expected 1/80002000/0", mem_awvalid, mem_awaddr, mem_wvalid); end
    tick();
    mem_awready = 1;
    @(negedge clk);
    checks++; if (exu_awready !== 1'b1) begin errors++; $display("FAIL st_aw_accept: got %b expected 1", exu_awready); end
    tick();
    mem_awready = 0; exu_awvalid = 0;
    mem_bvalid = 1; mem_bresp = 2'b00;
    @(negedge clk);
    checks++; if (exu_bvalid !== 1'b1 || exu_bresp !== 2'b00 || mem_bready !== 1'b1 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL st_b_route: got bvalid=%b bresp=%b bready=%b ifu_arready=%b expected 1/00/1/0", exu_bvalid, exu_bresp, mem_bready, ifu_arready); end
    tick();
    mem_bvalid = 0;
    @(negedge clk);
    checks++; if (grant !== 3'b000 || ifu_arready !== 1'b0 || exu_bvalid !== 1'b0) begin
      errors++; $display("FAIL st_back_idle: got grant=%b ifu_arready=%b bvalid=%b expected 000/0/0", grant, ifu_arready, exu_bvalid); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 3'b001 || ifu_arready !== 1'b1) begin
      errors++; $display("FAIL st_ifu_after: got grant=%b arready=%b expected 001/1", grant, ifu_arready); end
    serve_read(1'b0, 32'h33333333);
    clear_inputs();
  endtask

  task automatic test_write_read_collision();
    exu_awaddr = 32'h80002004; exu_awvalid = 1;
    exu_wdata = 32'h11223344; exu_wstrb = 3'b011; exu_wvalid = 1; exu_bready = 1;
    ifu_araddr = 32'h80000020; ifu_arvalid = 1; ifu_rready = 1;
    tick();
    mem_arready = 1; mem_awready = 1; mem_wready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b100 || ifu_arready !== 1'b0) begin
      errors++; $display("FAIL wr_coll_write_first: got grant=%b ifu_arready=%b expected 100/0", grant, ifu_arready); end
    checks++; if (exu_awready !== 1'b1 || exu_wready !== 1'b1 || mem_wstrb !== 3'b011) begin
      errors++; $display("FAIL wr_coll_aw_w_same: got awready=%b wready=%b wstrb=%b expected 1/1/011", exu_awready, exu_wready, mem_wstrb); end
    tick();
    exu_awvalid = 0; exu_wvalid = 0; mem_awready = 0; mem_wready = 0;
    mem_bvalid = 1; mem_bresp = 2'b01;
    @(negedge clk);
    checks++; if (exu_bvalid !== 1'b1 || exu_bresp !== 2'b01) begin
      errors++; $display("FAIL wr_coll_bresp: got bvalid=%b bresp=%b expected 1/01", exu_bvalid, exu_bresp); end
    tick();
    mem_bvalid = 0; mem_bresp = 2'b00;
    tick();
    @(negedge clk);
    checks++; if (grant !== 3'b001 || mem_araddr !== 32'h80000020) begin
      errors++; $display("FAIL wr_coll_ifu_second: got grant=%b araddr=%h expected 001/80000020", grant, mem_araddr); end
    serve_read(1'b0, 32'h44444444);
    clear_inputs();
  endtask

  task automatic test_reset_mid_read();
    exu_araddr = 32'h80003000; exu_arvalid = 1; exu_rready = 0;
    tick();
    mem_arready = 1;
    @(negedge clk);
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL mid_rst_grant: got %b expected 010", grant); end
    tick();
    mem_arready = 0; exu_arvalid = 0;
    mem_rvalid = 1; mem_rdata = 32'h55aa55aa;
    @(negedge clk);
    checks++; if (exu_rvalid !== 1'b1) begin errors++; $display("FAIL mid_rst_pending: got %b expected 1", exu_rvalid); end
    #2 rst = 1;
    #1;
    checks++; if (grant !== 3'b000 || exu_rvalid !== 1'b0 || exu_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_rst_async: got grant=%b rvalid=%b rdata=%h expected 000/0/0", grant, exu_rvalid, exu_rdata); end
    tick();
    tick();
    rst = 0; exu_rready = 1;
    @(negedge clk);
    checks++; if (exu_rvalid !== 1'b0 || mem_rready !== 1'b0 || grant !== 3'b000) begin
      errors++; $display("FAIL mid_rst_after: got rvalid=%b rready=%b grant=%b expected 0/0/000", exu_rvalid, mem_rready, grant); end
    tick();
    @(negedge clk);
    checks++; if (exu_rvalid !== 1'b0 || grant !== 3'b000) begin
      errors++; $display("FAIL mid_rst_stays_idle: got rvalid=%b grant=%b expected 0/000", exu_rvalid, grant); end
    tick();
    clear_inputs();
  endtask

  task automatic test_rresp_error();
    exu_araddr = 32'h80004000; exu_arvalid = 1; exu_rready = 1;
    tick();
    mem_arready = 1;
    tick();
    mem_arready = 0; exu_arvalid = 0;
    mem_rvalid = 1; mem_rresp = 2'b10; mem_rdata = 32'h0badf00d;
    @(negedge clk);
    checks++; if (exu_rvalid !== 1'b1 || exu_rresp !== 2'b10 || exu_rdata !== 32'h0badf00d) begin
      errors++; $display("FAIL rresp_forward: got rvalid=%b rresp=%b rdata=%h expected 1/10/0badf00d", exu_rvalid, exu_rresp, exu_rdata); end
    checks++; if (ifu_rvalid !== 1'b0 || ifu_rresp !== 2'b00) begin
      errors++; $display("FAIL rresp_ifu_quiet: got rvalid=%b rresp=%b expected 0/00", ifu_rvalid, ifu_rresp); end
    tick();
    mem_rvalid = 0; mem_rresp = 2'b00; mem_rdata = '0;
    @(negedge clk);
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rresp_back_idle: got %b expected 000", grant); end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_read_collision();
    test_exu_store();
    test_write_read_collision();
    test_reset_mid_read();
    test_rresp_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
